// File: rtl/vga_sync_to_count.sv
// Recovers pixel column/row counts from an incoming active-low HS/VS pair and tracks lock.
// Counts are seeded on sync falling edges; any disagreement with prediction drops lock.
module vga_sync_to_count #(
  parameter int unsigned TOTAL_COLS   = 800,
  parameter int unsigned TOTAL_ROWS   = 525,
  parameter int unsigned ACTIVE_COLS  = 640,
  parameter int unsigned ACTIVE_ROWS  = 480,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned LOCK_FRAMES  = 2,
  parameter int unsigned CNT_W        = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_H_Sync,
  input  logic             i_V_Sync,
  output logic             o_H_Sync,
  output logic             o_V_Sync,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Active,
  output logic             o_Locked,
  output logic             o_Frame_Start,
  output logic             o_Sync_Err
);

  localparam int unsigned GoodW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [CNT_W-1:0] ColLast  = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] RowLast  = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] ColAct   = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0] RowAct   = CNT_W'(ACTIVE_ROWS);
  localparam logic [CNT_W-1:0] HsCol    = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] VsRow    = CNT_W'(V_SYNC_START);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  state_e             state_q, state_d;
  logic [GoodW-1:0]   good_q, good_d;
  logic [CNT_W-1:0]   col_q, col_d, row_q, row_d;
  logic               h_q, v_q;
  logic               active_q, active_d;
  logic               locked_q, locked_d;
  logic               frame_q, frame_d;
  logic               err_q, err_d;

  logic               h_edge, v_edge, mismatch;
  logic [CNT_W-1:0]   col_n, row_n;

  assign h_edge = h_q & ~i_H_Sync;
  assign v_edge = v_q & ~i_V_Sync;

  always_comb begin
    col_n = (col_q == ColLast) ? '0 : col_q + 1'b1;
    row_n = row_q;
    if (col_q == ColLast) begin
      row_n = (row_q == RowLast) ? '0 : row_q + 1'b1;
    end
    mismatch = (h_edge && (col_n != HsCol)) ||
               (v_edge && ((row_n != VsRow) || (col_n != '0))) ||
               ((col_n == HsCol) && !h_edge) ||
               ((row_n == VsRow) && (col_n == '0) && !v_edge);
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = 1'b0;
    if (state_q == StSearch) begin
      // Only a VS edge gives a full coordinate; HS alone says nothing about the row.
      if (v_edge) begin
        row_d   = VsRow;
        col_d   = '0;
        good_d  = '0;
        state_d = StTrack;
      end
    end else begin
      col_d = col_n;
      row_d = row_n;
      if (h_edge) begin
        col_d = HsCol;
      end
      if (v_edge) begin
        row_d = VsRow;
        if (!h_edge) begin
          col_d = '0;
        end
      end
      if (mismatch) begin
        err_d   = 1'b1;
        good_d  = '0;
        state_d = StTrack;
      end else if (v_edge && (state_q == StTrack)) begin
        good_d = good_q + 1'b1;
        if (good_q == GoodLast) begin
          state_d = StLocked;
        end
      end
    end
  end

  always_comb begin
    locked_d = (state_d == StLocked);
    active_d = locked_d && (col_d < ColAct) && (row_d < RowAct);
    frame_d  = locked_d && (col_d == '0) && (row_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StSearch;
      good_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      h_q      <= 1'b1;
      v_q      <= 1'b1;
      active_q <= 1'b0;
      locked_q <= 1'b0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      col_q    <= col_d;
      row_q    <= row_d;
      h_q      <= i_H_Sync;
      v_q      <= i_V_Sync;
      active_q <= active_d;
      locked_q <= locked_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign o_H_Sync      = h_q;
  assign o_V_Sync      = v_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Active      = active_q;
  assign o_Locked      = locked_q;
  assign o_Frame_Start = frame_q;
  assign o_Sync_Err    = err_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Directed bench for vga_sync_to_count using a reduced 20x12 raster so whole frames stay short.
// A local sync generator drives the DUT; recovered counts must equal it one cycle later.
module tb_vga_sync_to_count;

  localparam int TC  = 20;
  localparam int TR  = 12;
  localparam int AC  = 16;
  localparam int AR  = 8;
  localparam int HS0 = 17;
  localparam int HSW = 2;
  localparam int VS0 = 9;
  localparam int VSW = 2;
  localparam int CW  = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          i_H_Sync = 1'b1;
  logic          i_V_Sync = 1'b1;
  logic          o_H_Sync, o_V_Sync, o_Active, o_Locked, o_Frame_Start, o_Sync_Err;
  logic [CW-1:0] o_Col_Count, o_Row_Count;

  int n_cmp = 0;
  int n_err = 0;
  int gen_col = 0;
  int gen_row = 0;
  bit omit_hs = 1'b0;
  bit track_chk = 1'b0;
  int active_cnt = 0;
  int frame_cnt = 0;
  int err_cnt = 0;

  vga_sync_to_count #(
    .TOTAL_COLS  (TC),
    .TOTAL_ROWS  (TR),
    .ACTIVE_COLS (AC),
    .ACTIVE_ROWS (AR),
    .H_SYNC_START(HS0),
    .V_SYNC_START(VS0),
    .LOCK_FRAMES (2),
    .CNT_W       (CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .i_H_Sync     (i_H_Sync),
    .i_V_Sync     (i_V_Sync),
    .o_H_Sync     (o_H_Sync),
    .o_V_Sync     (o_V_Sync),
    .o_Col_Count  (o_Col_Count),
    .o_Row_Count  (o_Row_Count),
    .o_Active     (o_Active),
    .o_Locked     (o_Locked),
    .o_Frame_Start(o_Frame_Start),
    .o_Sync_Err   (o_Sync_Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the generator's current position, clock once, then advance the generator.
  task automatic tick();
    i_H_Sync = omit_hs ? 1'b1 : !((gen_col >= HS0) && (gen_col < HS0 + HSW));
    i_V_Sync = !((gen_row >= VS0) && (gen_row < VS0 + VSW));
    @(posedge CLK);
    #1;
    if (track_chk) begin
      chk("col_track", 32'(o_Col_Count), 32'(gen_col));
      chk("row_track", 32'(o_Row_Count), 32'(gen_row));
    end
    active_cnt += int'(o_Active);
    frame_cnt  += int'(o_Frame_Start);
    err_cnt    += int'(o_Sync_Err);
    if (gen_col == TC - 1) begin
      gen_col = 0;
      gen_row = (gen_row == TR - 1) ? 0 : gen_row + 1;
    end else begin
      gen_col++;
    end
  endtask

  task automatic run_until(input int r, input int c);
    int n;
    n = 0;
    while (!((gen_row == r) && (gen_col == c))) begin
      tick();
      n++;
      if (n > 2000) begin
        n_cmp++;
        n_err++;
        $error("FAIL run_until_timeout: observed (%0d,%0d) expected (%0d,%0d)",
               gen_col, gen_row, c, r);
        break;
      end
    end
  endtask

  initial begin
    // Reset with syncs idle.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_col", 32'(o_Col_Count), 0);
    chk("rst_row", 32'(o_Row_Count), 0);
    chk("rst_hs", 32'(o_H_Sync), 1);
    chk("rst_vs", 32'(o_V_Sync), 1);
    chk("rst_active", 32'(o_Active), 0);
    chk("rst_locked", 32'(o_Locked), 0);
    chk("rst_frame", 32'(o_Frame_Start), 0);
    chk("rst_err", 32'(o_Sync_Err), 0);
    RST = 1'b0;

    // Acquire: first VS enters tracking, two more good VS edges lock.
    run_until(VS0, 0);
    chk("search_col", 32'(o_Col_Count), 0);
    chk("search_row", 32'(o_Row_Count), 0);
    tick();
    chk("seed_col", 32'(o_Col_Count), 0);
    chk("seed_row", 32'(o_Row_Count), VS0);
    chk("seed_vs", 32'(o_V_Sync), 0);
    track_chk = 1'b1;
    err_cnt = 0;
    run_until(VS0, 0);
    tick();
    chk("good1_locked", 32'(o_Locked), 0);
    run_until(VS0, 0);
    chk("prelock_locked", 32'(o_Locked), 0);
    tick();
    chk("lock_locked", 32'(o_Locked), 1);
    chk("acq_err", 32'(err_cnt), 0);

    // One full locked frame.
    active_cnt = 0;
    frame_cnt = 0;
    err_cnt = 0;
    run_until(VS0, 0);
    chk("frame_active_cnt", 32'(active_cnt), AC * AR);
    chk("frame_start_cnt", 32'(frame_cnt), 1);
    chk("frame_err_cnt", 32'(err_cnt), 0);
    chk("frame_locked", 32'(o_Locked), 1);

    // Column wrap and HS alignment.
    run_until(3, TC - 1);
    tick();
    chk("cwrap_pre_col", 32'(o_Col_Count), TC - 1);
    tick();
    chk("cwrap_col", 32'(o_Col_Count), 0);
    chk("cwrap_row", 32'(o_Row_Count), 4);
    run_until(4, HS0 - 1);
    tick();
    chk("hs_pre", 32'(o_H_Sync), 1);
    tick();
    chk("hs_fall", 32'(o_H_Sync), 0);
    chk("hs_fall_col", 32'(o_Col_Count), HS0);
    chk("active_off", 32'(o_Active), 0);

    // Frame wrap.
    run_until(TR - 1, TC - 1);
    tick();
    chk("fwrap_pre_fs", 32'(o_Frame_Start), 0);
    tick();
    chk("fwrap_fs", 32'(o_Frame_Start), 1);
    chk("fwrap_col", 32'(o_Col_Count), 0);
    chk("fwrap_row", 32'(o_Row_Count), 0);
    chk("fwrap_active", 32'(o_Active), 1);
    tick();
    chk("fwrap_post_fs", 32'(o_Frame_Start), 0);

    // HS one cycle early: generator skips a column.
    run_until(2, HS0 - 1);
    gen_col = HS0;
    err_cnt = 0;
    tick();
    chk("early_err", 32'(o_Sync_Err), 1);
    chk("early_locked", 32'(o_Locked), 0);
    chk("early_col", 32'(o_Col_Count), HS0);
    tick();
    chk("early_err_clear", 32'(o_Sync_Err), 0);
    run_until(VS0, 0);
    tick();
    chk("early_relock1", 32'(o_Locked), 0);
    run_until(VS0, 0);
    tick();
    chk("early_relock2", 32'(o_Locked), 1);
    chk("early_err_cnt", 32'(err_cnt), 1);

    // One HS pulse omitted.
    run_until(3, 0);
    omit_hs = 1'b1;
    err_cnt = 0;
    run_until(3, HS0);
    tick();
    chk("omit_err", 32'(o_Sync_Err), 1);
    chk("omit_col", 32'(o_Col_Count), HS0);
    chk("omit_locked", 32'(o_Locked), 0);
    run_until(4, 0);
    omit_hs = 1'b0;
    run_until(VS0, 0);
    tick();
    run_until(VS0, 0);
    tick();
    chk("omit_relock", 32'(o_Locked), 1);
    chk("omit_err_cnt", 32'(err_cnt), 1);

    // Reset mid-frame while locked.
    run_until(5, 10);
    tick();
    chk("midrst_pre_locked", 32'(o_Locked), 1);
    track_chk = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_col", 32'(o_Col_Count), 0);
    chk("midrst_row", 32'(o_Row_Count), 0);
    chk("midrst_locked", 32'(o_Locked), 0);
    chk("midrst_active", 32'(o_Active), 0);
    run_until(VS0, 0);
    chk("midrst_hold_col", 32'(o_Col_Count), 0);
    chk("midrst_hold_row", 32'(o_Row_Count), 0);
    tick();
    chk("midrst_seed_row", 32'(o_Row_Count), VS0);
    track_chk = 1'b1;
    run_until(VS0, 0);
    tick();
    chk("midrst_relock1", 32'(o_Locked), 0);
    run_until(VS0, 0);
    tick();
    chk("midrst_relock2", 32'(o_Locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
